// File: rtl/lcd_spi_writer.sv
// lcd_spi_writer: 9-bit word (D/C + byte) shifted out in SPI mode 0, MSB first; wr_done 16*CLK_DIV cycles after latch.
// en_write is a level, ignored until GAP_CYCLES after wr_done; optional LCD_SPI_CS_HOLD_EN keeps CS low across streamed bytes.
module lcd_spi_writer #(
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYCLES = 3
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       en_write,
    input  logic [8:0] data,
    output logic       wr_done,
    output logic       busy,
    output logic       lcd_sclk,
    output logic       lcd_mosi,
    output logic       lcd_dc,
    output logic       lcd_cs_n
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_div_cnt;
    logic [7:0] w_div_cnt_nxt;
    logic [2:0] r_bit_cnt;
    logic [2:0] w_bit_cnt_nxt;
    logic [3:0] r_gap_cnt;
    logic [3:0] w_gap_cnt_nxt;
    // bit 8 drives lcd_dc, bit 7 drives lcd_mosi; only bits 7:0 shift
    logic [8:0] r_shift;
    logic [8:0] w_shift_nxt;
    logic       r_sclk;
    logic       w_sclk_nxt;
    logic       r_cs_n;
    logic       w_cs_n_nxt;
    logic       r_wr_done;
    logic       w_wr_done_nxt;
    logic       r_busy;
    logic       w_busy_nxt;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state   <= IDLE;
            r_div_cnt <= 8'd0;
            r_bit_cnt <= 3'd0;
            r_gap_cnt <= 4'd0;
            r_shift   <= 9'd0;
            r_sclk    <= 1'b0;
            r_cs_n    <= 1'b1;
            r_wr_done <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_div_cnt <= w_div_cnt_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_sclk    <= w_sclk_nxt;
            r_cs_n    <= w_cs_n_nxt;
            r_wr_done <= w_wr_done_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_div_cnt_nxt = r_div_cnt;
        w_bit_cnt_nxt = r_bit_cnt;
        w_gap_cnt_nxt = r_gap_cnt;
        w_shift_nxt   = r_shift;
        w_sclk_nxt    = r_sclk;
        w_cs_n_nxt    = r_cs_n;
        w_wr_done_nxt = 1'b0;
        w_busy_nxt    = r_busy;

        case (r_state)
            IDLE: begin
                if (en_write) begin
                    w_state_nxt   = SHIFT;
                    w_shift_nxt   = data;
                    w_div_cnt_nxt = 8'd0;
                    w_bit_cnt_nxt = 3'd0;
                    w_sclk_nxt    = 1'b0;
                    w_cs_n_nxt    = 1'b0;
                    w_busy_nxt    = 1'b1;
                end else begin
                    w_cs_n_nxt = 1'b1;
                end
            end

            SHIFT: begin
                if (r_div_cnt == DIV_LAST) begin
                    w_div_cnt_nxt = 8'd0;
                    w_sclk_nxt    = ~r_sclk;
                    // falling SCLK: present next bit while the clock is low
                    if (r_sclk) begin
                        w_shift_nxt[7:0] = {r_shift[6:0], 1'b0};
                        w_bit_cnt_nxt    = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            w_state_nxt   = GAP;
                            w_gap_cnt_nxt = 4'd0;
                            w_wr_done_nxt = 1'b1;
`ifdef LCD_SPI_CS_HOLD_EN
                            w_cs_n_nxt    = ~en_write;
`else
                            w_cs_n_nxt    = 1'b1;
`endif
                        end
                    end
                end else begin
                    w_div_cnt_nxt = r_div_cnt + 8'd1;
                end
            end

            GAP: begin
`ifdef LCD_SPI_CS_HOLD_EN
                if (!en_write) begin
                    w_cs_n_nxt = 1'b1;
                end
`endif
                if (r_gap_cnt == GAP_LAST) begin
                    w_state_nxt = IDLE;
                    w_busy_nxt  = 1'b0;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + 4'd1;
                end
            end

            default: begin
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
                w_cs_n_nxt  = 1'b1;
            end
        endcase
    end

    assign wr_done  = r_wr_done;
    assign busy     = r_busy;
    assign lcd_sclk = r_sclk;
    assign lcd_mosi = r_shift[7];
    assign lcd_dc   = r_shift[8];
    assign lcd_cs_n = r_cs_n;

endmodule

// File: tb/tb_lcd_spi_writer.sv
// Bench for lcd_spi_writer: instance A (CLK_DIV=2, GAP=3) and instance B (CLK_DIV=1, GAP=1) against a timing/byte model.
module tb_lcd_spi_writer;

    localparam int CD_A = 2;
    localparam int G_A  = 3;
    localparam int CD_B = 1;
    localparam int G_B  = 1;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n   [2];
    logic       en      [2];
    logic [8:0] dat     [2];
    logic       wr_done [2];
    logic       busy    [2];
    logic       sclk    [2];
    logic       mosi    [2];
    logic       dc      [2];
    logic       cs_n    [2];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    lcd_spi_writer #(.CLK_DIV(CD_A), .GAP_CYCLES(G_A)) u_a (
        .sys_clk(clk), .sys_rst_n(rst_n[0]), .en_write(en[0]), .data(dat[0]),
        .wr_done(wr_done[0]), .busy(busy[0]), .lcd_sclk(sclk[0]), .lcd_mosi(mosi[0]),
        .lcd_dc(dc[0]), .lcd_cs_n(cs_n[0])
    );

    lcd_spi_writer #(.CLK_DIV(CD_B), .GAP_CYCLES(G_B)) u_b (
        .sys_clk(clk), .sys_rst_n(rst_n[1]), .en_write(en[1]), .data(dat[1]),
        .wr_done(wr_done[1]), .busy(busy[1]), .lcd_sclk(sclk[1]), .lcd_mosi(mosi[1]),
        .lcd_dc(dc[1]), .lcd_cs_n(cs_n[1])
    );

    // Observed SPI traffic per instance: bytes seen on SCLK rising edges and event edge indices
    logic [7:0] rx_byte [2][256];
    logic       rx_dc   [2][256];
    int         rx_n    [2];
    int         done_t  [2][256];
    int         done_n  [2];
    int         lat_t   [2][256];
    int         lat_n   [2];
    int         rise_t  [2][256];
    int         rise_n  [2];
    int         cs_fall_n [2];
    int         cs_rise_n [2];
    int         cs_fall_t [2];
    int         cs_rise_t [2];
    logic [7:0] acc     [2];
    int         nbits   [2];
    logic       p_sclk  [2];
    logic       p_busy  [2];
    logic       p_cs    [2];

    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n[d]) begin
                nbits[d]  = 0;
                p_sclk[d] = 1'b0;
                p_busy[d] = 1'b0;
                p_cs[d]   = 1'b1;
            end else begin
                if (sclk[d] && !p_sclk[d]) begin
                    if (rise_n[d] < 256) rise_t[d][rise_n[d]] = cyc;
                    rise_n[d]++;
                    acc[d] = {acc[d][6:0], mosi[d]};
                    nbits[d]++;
                    if (nbits[d] == 8) begin
                        if (rx_n[d] < 256) begin
                            rx_byte[d][rx_n[d]] = acc[d];
                            rx_dc[d][rx_n[d]]   = dc[d];
                        end
                        rx_n[d]++;
                        nbits[d] = 0;
                    end
                end
                if (wr_done[d]) begin
                    if (done_n[d] < 256) done_t[d][done_n[d]] = cyc;
                    done_n[d]++;
                end
                if (busy[d] && !p_busy[d]) begin
                    if (lat_n[d] < 256) lat_t[d][lat_n[d]] = cyc;
                    lat_n[d]++;
                end
                if (!cs_n[d] && p_cs[d]) begin
                    cs_fall_n[d]++;
                    cs_fall_t[d] = cyc;
                end
                if (cs_n[d] && !p_cs[d]) begin
                    cs_rise_n[d]++;
                    cs_rise_t[d] = cyc;
                end
                p_sclk[d] = sclk[d];
                p_busy[d] = busy[d];
                p_cs[d]   = cs_n[d];
            end
        end
    end

    task automatic clear_mon(input int d);
        rx_n[d] = 0; done_n[d] = 0; lat_n[d] = 0; rise_n[d] = 0;
        cs_fall_n[d] = 0; cs_rise_n[d] = 0; cs_fall_t[d] = -1; cs_rise_t[d] = -1;
        nbits[d] = 0;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; en[d] = 1'b0; dat[d] = 9'h000;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            total++;
            if ({wr_done[d], busy[d], sclk[d], mosi[d], dc[d], cs_n[d]} !== 6'b000001) begin
                bad++;
                $display("FAIL reset_outputs dut=%0d got=%b want=000001", d,
                         {wr_done[d], busy[d], sclk[d], mosi[d], dc[d], cs_n[d]});
            end
        end
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        clear_mon(0); clear_mon(1);
        repeat (20) @(negedge clk);
        total++;
        if (cs_fall_n[0] + cs_fall_n[1] !== 0) begin
            bad++; $display("FAIL idle_cs_falls got=%0d want=0", cs_fall_n[0] + cs_fall_n[1]);
        end
        total++;
        if (done_n[0] + done_n[1] !== 0) begin
            bad++; $display("FAIL idle_wr_done got=%0d want=0", done_n[0] + done_n[1]);
        end
        total++;
        if ({sclk[0], cs_n[0], busy[0]} !== 3'b010) begin
            bad++; $display("FAIL idle_outputs got=%b want=010", {sclk[0], cs_n[0], busy[0]});
        end
    endtask

    task automatic test_single();
        int e0, w;
        clear_mon(0);
        @(negedge clk);
        dat[0] = 9'h02A; en[0] = 1'b1; e0 = cyc + 1;
        @(negedge clk);
        en[0] = 1'b0; dat[0] = 9'($urandom);
        for (int t = 0; t < 100 && done_n[0] < 1; t++) @(negedge clk);
        repeat (10) @(negedge clk);
        w = e0 + 16 * CD_A;
        total++;
        if (done_n[0] !== 1) begin bad++; $display("FAIL single_done_count got=%0d want=1", done_n[0]); end
        total++;
        if (rx_n[0] !== 1 || rx_byte[0][0] !== 8'h2A) begin
            bad++; $display("FAIL single_byte got=%0h (n=%0d) want=2a", rx_byte[0][0], rx_n[0]);
        end
        total++;
        if (rx_dc[0][0] !== 1'b0) begin bad++; $display("FAIL single_dc got=%b want=0", rx_dc[0][0]); end
        total++;
        if (lat_t[0][0] !== e0) begin bad++; $display("FAIL single_latch got=%0d want=%0d", lat_t[0][0], e0); end
        total++;
        if (done_t[0][0] !== w) begin bad++; $display("FAIL single_done_time got=%0d want=%0d", done_t[0][0], w); end
        total++;
        if (rise_n[0] !== 8) begin bad++; $display("FAIL single_rise_count got=%0d want=8", rise_n[0]); end
        for (int k = 0; k < 8; k++) begin
            total++;
            if (rise_t[0][k] !== e0 + (2 * k + 1) * CD_A) begin
                bad++; $display("FAIL single_rise_time k=%0d got=%0d want=%0d", k, rise_t[0][k], e0 + (2 * k + 1) * CD_A);
            end
        end
        total++;
        if (cs_fall_t[0] !== e0 || cs_rise_t[0] !== w) begin
            bad++; $display("FAIL single_cs_window got=%0d..%0d want=%0d..%0d", cs_fall_t[0], cs_rise_t[0], e0, w);
        end
    endtask

    task automatic test_back_to_back();
        int e0, w0, e1;
        clear_mon(0);
        @(negedge clk);
        dat[0] = 9'h1F8; en[0] = 1'b1; e0 = cyc + 1;
        w0 = e0 + 16 * CD_A;
        e1 = w0 + G_A + 1;
        for (int t = 0; t < 200 && done_n[0] < 1; t++) @(negedge clk);
        total++;
        if (done_n[0] < 1) begin bad++; $display("FAIL b2b_timeout_first got=%0d want=1", done_n[0]); end
        repeat (2) @(negedge clk);
        dat[0] = 9'h100;
        for (int t = 0; t < 50 && lat_n[0] < 2; t++) @(negedge clk);
        en[0] = 1'b0;
        for (int t = 0; t < 200 && done_n[0] < 2; t++) @(negedge clk);
        repeat (60) @(negedge clk);
        total++;
        if (rx_n[0] !== 2 || lat_n[0] !== 2) begin
            bad++; $display("FAIL b2b_count got=%0d bytes %0d latches want=2 2", rx_n[0], lat_n[0]);
        end
        total++;
        if (rx_byte[0][0] !== 8'hF8 || rx_byte[0][1] !== 8'h00) begin
            bad++; $display("FAIL b2b_bytes got=%0h %0h want=f8 00", rx_byte[0][0], rx_byte[0][1]);
        end
        total++;
        if (rx_dc[0][0] !== 1'b1 || rx_dc[0][1] !== 1'b1) begin
            bad++; $display("FAIL b2b_dc got=%b%b want=11", rx_dc[0][0], rx_dc[0][1]);
        end
        total++;
        if (done_t[0][0] !== w0) begin bad++; $display("FAIL b2b_first_done got=%0d want=%0d", done_t[0][0], w0); end
        total++;
        if (lat_t[0][1] !== e1) begin bad++; $display("FAIL b2b_second_latch got=%0d want=%0d", lat_t[0][1], e1); end
        total++;
        if (done_t[0][1] !== e1 + 16 * CD_A) begin
            bad++; $display("FAIL b2b_second_done got=%0d want=%0d", done_t[0][1], e1 + 16 * CD_A);
        end
    endtask

    task automatic test_reset_midbyte();
        logic [8:0] d1, d2;
        d1 = 9'($urandom); d2 = 9'($urandom);
        clear_mon(0);
        @(negedge clk);
        dat[0] = d1; en[0] = 1'b1;
        @(negedge clk);
        en[0] = 1'b0;
        for (int t = 0; t < 100 && rise_n[0] < 3; t++) @(negedge clk);
        #1 rst_n[0] = 1'b0;
        #1;
        total++;
        if ({wr_done[0], busy[0], sclk[0], mosi[0], dc[0], cs_n[0]} !== 6'b000001) begin
            bad++; $display("FAIL midreset_outputs got=%b want=000001",
                            {wr_done[0], busy[0], sclk[0], mosi[0], dc[0], cs_n[0]});
        end
        @(negedge clk);
        @(negedge clk);
        rst_n[0] = 1'b1;
        repeat (60) @(negedge clk);
        total++;
        if (done_n[0] !== 0 || rx_n[0] !== 0) begin
            bad++; $display("FAIL midreset_aborted got=%0d done %0d bytes want=0 0", done_n[0], rx_n[0]);
        end
        @(negedge clk);
        dat[0] = d2; en[0] = 1'b1;
        @(negedge clk);
        en[0] = 1'b0;
        for (int t = 0; t < 100 && done_n[0] < 1; t++) @(negedge clk);
        repeat (10) @(negedge clk);
        total++;
        if (rx_n[0] !== 1 || rx_byte[0][0] !== d2[7:0] || rx_dc[0][0] !== d2[8]) begin
            bad++; $display("FAIL midreset_next_byte got=%0h dc=%b n=%0d want=%0h dc=%b",
                            rx_byte[0][0], rx_dc[0][0], rx_n[0], d2[7:0], d2[8]);
        end
        total++;
        if (rise_n[0] !== 3 + 8) begin bad++; $display("FAIL midreset_rises got=%0d want=11", rise_n[0]); end
    endtask

    task automatic test_stream();
        logic [8:0] words [11];
        int period;
        period = 16 * CD_B + G_B + 1;
        for (int i = 0; i < 11; i++) words[i] = 9'($urandom);
        clear_mon(1);
        @(negedge clk);
        dat[1] = words[0]; en[1] = 1'b1;
        for (int i = 0; i < 11; i++) begin
            for (int t = 0; t < 100 && done_n[1] <= i; t++) @(negedge clk);
            if (i < 10) dat[1] = words[i + 1];
            else        en[1] = 1'b0;
        end
        en[1] = 1'b0;
        repeat (20) @(negedge clk);
        total++;
        if (done_n[1] !== 11 || rx_n[1] !== 11) begin
            bad++; $display("FAIL stream_count got=%0d done %0d bytes want=11 11", done_n[1], rx_n[1]);
        end
        for (int i = 0; i < 11; i++) begin
            total++;
            if (rx_byte[1][i] !== words[i][7:0] || rx_dc[1][i] !== words[i][8]) begin
                bad++; $display("FAIL stream_byte i=%0d got=%0h dc=%b want=%0h dc=%b",
                                i, rx_byte[1][i], rx_dc[1][i], words[i][7:0], words[i][8]);
            end
        end
        for (int i = 1; i < 11; i++) begin
            total++;
            if (done_t[1][i] - done_t[1][i - 1] !== period) begin
                bad++; $display("FAIL stream_spacing i=%0d got=%0d want=%0d", i, done_t[1][i] - done_t[1][i - 1], period);
            end
        end
    endtask

    task automatic test_random();
        logic [8:0] exp_w [6];
        int plen;
        clear_mon(0);
        for (int i = 0; i < 6; i++) begin
            for (int t = 0; t < 100 && busy[0] !== 1'b0; t++) @(negedge clk);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            exp_w[i] = 9'($urandom);
            dat[0] = exp_w[i]; en[0] = 1'b1;
            plen = $urandom_range(1, 20);
            for (int j = 0; j < plen; j++) begin
                @(negedge clk);
                dat[0] = 9'($urandom);
            end
            en[0] = 1'b0;
        end
        for (int t = 0; t < 200 && done_n[0] < 6; t++) @(negedge clk);
        repeat (10) @(negedge clk);
        total++;
        if (done_n[0] !== 6 || rx_n[0] !== 6) begin
            bad++; $display("FAIL random_count got=%0d done %0d bytes want=6 6", done_n[0], rx_n[0]);
        end
        for (int i = 0; i < 6; i++) begin
            total++;
            if (rx_byte[0][i] !== exp_w[i][7:0] || rx_dc[0][i] !== exp_w[i][8]) begin
                bad++; $display("FAIL random_byte i=%0d got=%0h dc=%b want=%0h dc=%b",
                                i, rx_byte[0][i], rx_dc[0][i], exp_w[i][7:0], exp_w[i][8]);
            end
            total++;
            if (done_t[0][i] - lat_t[0][i] !== 16 * CD_A) begin
                bad++; $display("FAIL random_latency i=%0d got=%0d want=%0d", i, done_t[0][i] - lat_t[0][i], 16 * CD_A);
            end
        end
    endtask

    task automatic test_cs_frames();
        int e0, w_last, seen, exp_frames;
`ifdef LCD_SPI_CS_HOLD_EN
        exp_frames = 1;
`else
        exp_frames = 3;
`endif
        clear_mon(0);
        seen = 0;
        @(negedge clk);
        dat[0] = 9'($urandom); en[0] = 1'b1; e0 = cyc + 1;
        w_last = e0 + 2 * (16 * CD_A + G_A + 1) + 16 * CD_A;
        for (int t = 0; t < 400 && lat_n[0] < 3; t++) begin
            @(negedge clk);
            if (done_n[0] != seen) begin
                seen = done_n[0];
                dat[0] = 9'($urandom);
            end
        end
        en[0] = 1'b0;
        for (int t = 0; t < 200 && done_n[0] < 3; t++) @(negedge clk);
        repeat (20) @(negedge clk);
        total++;
        if (done_n[0] !== 3) begin bad++; $display("FAIL cs_done_count got=%0d want=3", done_n[0]); end
        total++;
        if (cs_fall_n[0] !== exp_frames || cs_rise_n[0] !== exp_frames) begin
            bad++; $display("FAIL cs_frames got=%0d falls %0d rises want=%0d", cs_fall_n[0], cs_rise_n[0], exp_frames);
        end
        total++;
        if (cs_rise_t[0] !== w_last) begin bad++; $display("FAIL cs_last_rise got=%0d want=%0d", cs_rise_t[0], w_last); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_reset_midbyte();
        test_stream();
        test_random();
        test_cs_frames();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
